// File: rtl/stall_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package stall_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in ID/EX whose destination
// feeds either source of the instruction in IF/ID (register zero excluded).
module load_use_detect #(
  parameter int ADDR_W = stall_pkg::REG_ADDR_W
) (
  input  logic              idex_memread,
  input  logic [ADDR_W-1:0] idex_rt,
  input  logic [ADDR_W-1:0] ifid_rs,
  input  logic [ADDR_W-1:0] ifid_rt,
  output logic              load_use
);
  import stall_pkg::*;

  logic w_dest_nonzero;
  logic w_src_match;

  assign w_dest_nonzero = (idex_rt != ADDR_W'(REG_ZERO));
  assign w_src_match    = (idex_rt == ifid_rs) || (idex_rt == ifid_rt);
  assign load_use       = idex_memread && w_dest_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// PC / IF/ID / ID/EX hold-flush sequencer with Mealy enables.
// Optional stall/flush cycle counters are built when STALL_PERF_EN is defined.
module pipeline_stall_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_ADDR_W   = stall_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  branch_taken,
  input  logic                  jump,
  output logic                  pc_wren,
  output logic                  ifid_wren,
  output logic                  ifid_flush,
  output logic                  idex_bubble
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);
  import stall_pkg::*;

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_load_use;
  logic             w_redirect;

  load_use_detect #(.ADDR_W(REG_ADDR_W)) u_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use     (w_load_use)
  );

  assign w_redirect = branch_taken | jump;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    pc_wren      = 1'b1;
    ifid_wren    = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    case (r_state)
      RUN, STALL: begin
        if (w_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next_state = FLUSH;
            w_next_cnt   = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            w_next_state = RUN;
            w_next_cnt   = '0;
          end
        end else if (r_state == STALL || w_load_use) begin
          pc_wren     = 1'b0;
          ifid_wren   = 1'b0;
          idex_bubble = 1'b1;
          if (r_state == RUN) begin
            if (STALL_CYCLES > 1) begin
              w_next_state = STALL;
              w_next_cnt   = CNT_W'(STALL_CYCLES - 1);
            end
          end else if (r_cnt == CNT_W'(1)) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        // load_use is deliberately ignored: IF/ID is being cleared anyway.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (w_redirect) begin
          w_next_cnt = CNT_W'(FLUSH_CYCLES - 1);
        end else if (r_cnt == CNT_W'(1)) begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    endcase
    if (!rst_n) begin
      pc_wren     = 1'b0;
      ifid_wren   = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_wren)   r_stall_cnt <= r_stall_cnt + 32'd1;
      if (ifid_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: three parameterisations share inputs.
// Output nibble order is {pc_wren, ifid_wren, ifid_flush, idex_bubble}.
module tb_pipeline_stall_ctrl;

  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_FLUSH = 4'b1111;
  localparam logic [3:0] O_STALL = 4'b0001;
  localparam logic [3:0] O_RESET = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rt = '0;
  logic [4:0] ifid_rs = '0;
  logic [4:0] ifid_rt = '0;
  logic       branch_taken = 1'b0;
  logic       jump = 1'b0;

  logic pc_d, iw_d, fl_d, bb_d;
  logic pc_f, iw_f, fl_f, bb_f;
  logic pc_s, iw_s, fl_s, bb_s;
  logic [3:0] o_def, o_f3, o_s4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef STALL_PERF_EN
  logic [31:0] sc_d, fc_d, sc_f, fc_f, sc_s, fc_s;
`endif

  pipeline_stall_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .REG_ADDR_W(5)) dut_def (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .jump(jump),
    .pc_wren(pc_d), .ifid_wren(iw_d), .ifid_flush(fl_d), .idex_bubble(bb_d)
`ifdef STALL_PERF_EN
    , .stall_cnt(sc_d), .flush_cnt(fc_d)
`endif
  );

  pipeline_stall_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(3), .REG_ADDR_W(5)) dut_f3 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .jump(jump),
    .pc_wren(pc_f), .ifid_wren(iw_f), .ifid_flush(fl_f), .idex_bubble(bb_f)
`ifdef STALL_PERF_EN
    , .stall_cnt(sc_f), .flush_cnt(fc_f)
`endif
  );

  pipeline_stall_ctrl #(.STALL_CYCLES(4), .FLUSH_CYCLES(1), .REG_ADDR_W(5)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .jump(jump),
    .pc_wren(pc_s), .ifid_wren(iw_s), .ifid_flush(fl_s), .idex_bubble(bb_s)
`ifdef STALL_PERF_EN
    , .stall_cnt(sc_s), .flush_cnt(fc_s)
`endif
  );

  assign o_def = {pc_d, iw_d, fl_d, bb_d};
  assign o_f3  = {pc_f, iw_f, fl_f, bb_f};
  assign o_s4  = {pc_s, iw_s, fl_s, bb_s};

  // Apply one cycle of inputs at the falling edge and settle before checking.
  task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic jp);
    @(negedge clk);
    idex_memread = mr;
    idex_rt      = irt;
    ifid_rs      = rs;
    ifid_rt      = rt;
    branch_taken = br;
    jump         = jp;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idex_memread = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    branch_taken = 1'b0; jump = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o_def !== O_RESET) begin n_fail++; $display("FAIL reset_def[%0d]: got %b want %b", i, o_def, O_RESET); end
      n_checks++;
      if (o_s4 !== O_RESET) begin n_fail++; $display("FAIL reset_s4[%0d]: got %b want %b", i, o_s4, O_RESET); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_def !== O_RUN) begin n_fail++; $display("FAIL reset_release: got %b want %b", o_def, O_RUN); end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (o_f3 !== O_RUN) begin n_fail++; $display("FAIL reset_first_run: got %b want %b", o_f3, O_RUN); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 8, 8, 3, 0, 0);
    n_checks++;
    if (o_def !== O_STALL) begin n_fail++; $display("FAIL lu_rs_hold: got %b want %b", o_def, O_STALL); end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (o_def !== O_RUN) begin n_fail++; $display("FAIL lu_rs_release: got %b want %b", o_def, O_RUN); end
    drive(1, 12, 4, 12, 0, 0);
    n_checks++;
    if (o_def !== O_STALL) begin n_fail++; $display("FAIL lu_rt_hold: got %b want %b", o_def, O_STALL); end
    drive(0, 12, 12, 12, 0, 0);
    n_checks++;
    if (o_def !== O_RUN) begin n_fail++; $display("FAIL lu_no_load: got %b want %b", o_def, O_RUN); end
    drive(1, 9, 8, 10, 0, 0);
    n_checks++;
    if (o_def !== O_RUN) begin n_fail++; $display("FAIL lu_no_match: got %b want %b", o_def, O_RUN); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_def !== O_RUN) begin n_fail++; $display("FAIL lu_reg0[%0d]: got %b want %b", i, o_def, O_RUN); end
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch_flush();
    logic [3:0] exp_f3 [5] = '{O_FLUSH, O_FLUSH, O_FLUSH, O_RUN, O_RUN};
    logic [3:0] exp_d  [5] = '{O_FLUSH, O_RUN, O_RUN, O_RUN, O_RUN};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, (i == 0), 0);
      n_checks++;
      if (o_f3 !== exp_f3[i]) begin n_fail++; $display("FAIL flush3[%0d]: got %b want %b", i, o_f3, exp_f3[i]); end
      n_checks++;
      if (o_def !== exp_d[i]) begin n_fail++; $display("FAIL flush1[%0d]: got %b want %b", i, o_def, exp_d[i]); end
    end
    $display("test_branch_flush done");
  endtask

  task automatic test_flush_restart();
    logic       br [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic       mr [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [3:0] ex [7] = '{O_FLUSH, O_FLUSH, O_FLUSH, O_FLUSH, O_FLUSH, O_STALL, O_RUN};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(mr[i], 8, 8, 0, br[i], 0);
      n_checks++;
      if (o_f3 !== ex[i]) begin n_fail++; $display("FAIL flush_restart[%0d]: got %b want %b", i, o_f3, ex[i]); end
    end
    $display("test_flush_restart done");
  endtask

  task automatic test_long_stall();
    logic       mr [5] = '{1, 1, 0, 0, 0};
    logic [3:0] ex [5] = '{O_STALL, O_STALL, O_STALL, O_STALL, O_RUN};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(mr[i], 7, 2, 7, 0, 0);
      n_checks++;
      if (o_s4 !== ex[i]) begin n_fail++; $display("FAIL stall4[%0d]: got %b want %b", i, o_s4, ex[i]); end
    end
    $display("test_long_stall done");
  endtask

  task automatic test_redirect_in_stall();
    do_reset();
    drive(1, 8, 8, 0, 0, 0);
    n_checks++;
    if (o_s4 !== O_STALL) begin n_fail++; $display("FAIL rds_start: got %b want %b", o_s4, O_STALL); end
    drive(1, 8, 8, 0, 0, 1);
    n_checks++;
    if (o_s4 !== O_FLUSH) begin n_fail++; $display("FAIL rds_jump: got %b want %b", o_s4, O_FLUSH); end
    n_checks++;
    if (o_def !== O_FLUSH) begin n_fail++; $display("FAIL rds_jump_prio: got %b want %b", o_def, O_FLUSH); end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (o_s4 !== O_RUN) begin n_fail++; $display("FAIL rds_abandon: got %b want %b", o_s4, O_RUN); end
    $display("test_redirect_in_stall done");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 5, 5, 0, 0, 0);
    n_checks++;
    if (o_s4 !== O_STALL) begin n_fail++; $display("FAIL rms_start: got %b want %b", o_s4, O_STALL); end
    @(negedge clk);
    rst_n = 1'b0;
    idex_memread = 1'b0;
    #1;
    n_checks++;
    if (o_s4 !== O_RESET) begin n_fail++; $display("FAIL rms_in_reset: got %b want %b", o_s4, O_RESET); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_s4 !== O_RUN) begin n_fail++; $display("FAIL rms_after: got %b want %b", o_s4, O_RUN); end
    $display("test_reset_mid_stall done");
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    do_reset();
    drive(1, 8, 8, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (sc_f !== 32'd1) begin n_fail++; $display("FAIL perf_stall: got %0d want 1", sc_f); end
    n_checks++;
    if (fc_f !== 32'd3) begin n_fail++; $display("FAIL perf_flush: got %0d want 3", fc_f); end
    $display("test_perf done");
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch_flush();
    test_flush_restart();
    test_long_stall();
    test_redirect_in_stall();
    test_reset_mid_stall();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Generates the write enables, flushes and bubble controls for the CPU's PC and pipeline word latches. It monitors load-use hazards from the ID/EX stage and taken branches and jumps from EX, then sequences stall and flush windows so the latches either hold, advance or clear. It sits beside the PC register and the IF/ID and ID/EX latches, and drives their `pc_wren` and `ifid_wren` ports directly.

## Interface
- `STALL_CYCLES`, default 1: cycles the PC and IF/ID are held per load-use hazard; legal range 1..15.
- `FLUSH_CYCLES`, default 1: bubble cycles per taken branch or jump; legal range 1..15.
- `REG_ADDR_W`, default 5: register specifier width.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `idex_memread` input, 1 bit: the instruction in ID/EX is a load.
- `idex_rt` input, `REG_ADDR_W` bits: destination register of that load.
- `ifid_rs` and `ifid_rt` inputs, `REG_ADDR_W` bits each: source registers of the instruction in IF/ID.
- `branch_taken` input, 1 bit: EX resolved a taken branch.
- `jump` input, 1 bit: EX holds a jump.
- `pc_wren` output, 1 bit: PC latch write enable.
- `ifid_wren` output, 1 bit: IF/ID latch write enable.
- `ifid_flush` output, 1 bit: IF/ID loads a NOP instead of the fetched word.
- `idex_bubble` output, 1 bit: ID/EX loads a NOP.
- `stall_cnt` output, 32 bits: stall-cycle counter; present only under `STALL_PERF_EN`.
- `flush_cnt` output, 32 bits: flush-cycle counter; present only under `STALL_PERF_EN`.

## Operation
- **Hazard definitions.**
  - `load_use = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt)`.
  - `redirect = branch_taken | jump`.
- **State and counter.** Three states, RUN, STALL and FLUSH, plus a 4-bit down-counter `cnt`.
- **Output priority.** Outputs are combinational from state and inputs (Mealy), so a hazard takes effect at the very next edge. Redirect has priority over load-use in every state.
- **RUN:**
  - No hazard: `pc_wren=1`, `ifid_wren=1`, `ifid_flush=0`, `idex_bubble=0`; stay in RUN.
  - redirect: `pc_wren=1`, `ifid_wren=1`, `ifid_flush=1`, `idex_bubble=1`. If `FLUSH_CYCLES>1`, go to FLUSH with `cnt=FLUSH_CYCLES-1`; otherwise stay in RUN.
  - load_use without redirect: `pc_wren=0`, `ifid_wren=0`, `ifid_flush=0`, `idex_bubble=1`. If `STALL_CYCLES>1`, go to STALL with `cnt=STALL_CYCLES-1`; otherwise stay in RUN.
- **STALL:**
  - Outputs match the RUN load_use case.
  - `cnt` decrements each cycle; when `cnt==1`, the next state is RUN.
  - A redirect arriving in STALL abandons the stall and behaves as RUN+redirect, reloading `cnt`.
- **FLUSH:**
  - Outputs match the RUN redirect case.
  - `cnt` decrements each cycle; when `cnt==1`, the next state is RUN.
  - A new redirect in FLUSH restarts the window with `cnt=FLUSH_CYCLES-1`.
  - load_use is ignored in FLUSH, because IF/ID is being cleared.
- **Reset:**
  - While `rst_n=0`: `pc_wren=0`, `ifid_wren=0`, `ifid_flush=1`, `idex_bubble=1`; state is RUN and `cnt=0`.
  - Reset asserted mid-STALL or mid-FLUSH abandons the sequence immediately.
  - After release, the first cycle behaves as RUN.
- **Register zero.** An `idex_rt` of 0 never produces a stall.

## Timing
- Latency from a hazard input to a changed enable is zero cycles (combinational); the latches see it at the same rising edge.
- Number of consecutive held edges per load-use:
  - `STALL_CYCLES`, when the load stays in ID/EX.
  - 1, when `STALL_CYCLES=1`, because the bubble advances the load and clears `load_use` on the next cycle.
- Consecutive flush edges per redirect: exactly `FLUSH_CYCLES`.
- Hazard inputs are required to be valid and glitch-settled before the rising edge; no input is registered.

## Configuration
- **`STALL_PERF_EN` defined:**
  - `stall_cnt` increments on every edge with `pc_wren=0` while `rst_n=1`.
  - `flush_cnt` increments on every edge with `ifid_flush=1` while `rst_n=1`.
  - Both counters wrap modulo 2^32 and reset to 0.
- **`STALL_PERF_EN` undefined:** both ports and both counters are absent; all other behaviour is identical.

## Structure
- Package `stall_pkg` holds:
  - the state enum typedef (RUN, STALL, FLUSH);
  - `REG_ADDR_W`;
  - the constant `REG_ZERO = 0`;
  - the 4-bit counter width.
- One sub-module, `load_use_detect`, computes `load_use` combinationally from `idex_memread`, `idex_rt`, `ifid_rs` and `ifid_rt`.
- The state machine, counter and optional perf counters live in `pipeline_stall_ctrl`.

## Test plan
- **Reset:** hold `rst_n=0` for 3 edges → `pc_wren=0`, `ifid_wren=0`, `ifid_flush=1`, `idex_bubble=1`; release → with no hazards, `pc_wren=1` on the next edge.
- **Load-use, default stall:** `idex_memread=1`, `idex_rt=8`, `ifid_rs=8`, defaults → exactly 1 edge with `pc_wren=0`, `ifid_wren=0`, `idex_bubble=1`; the next edge has `pc_wren=1`.
- **Load-use on register 0:** `idex_rt=0`, `ifid_rt=0`, `idex_memread=1` → no stall; `pc_wren` stays 1.
- **Branch with longer flush:** `FLUSH_CYCLES=3`, pulse `branch_taken` for 1 cycle → `ifid_flush=1` and `idex_bubble=1` for 3 edges with `pc_wren=1`, then RUN.
- **Redirect during stall:** `STALL_CYCLES=4`, start a load-use, assert `jump` on the 2nd stall cycle → `pc_wren=1` and `ifid_flush=1` that cycle, and the stall is abandoned.
- **Perf counters:** with `STALL_PERF_EN`, one stall plus one 3-cycle flush → `stall_cnt=1`, `flush_cnt=3`.
